npu_spi_frame_slave: RTL and testbench
======================================

Name: npu_spi_frame_slave

Overview:
- Parametrised SPI mode-0 slave and command-frame decoder for the NPU system host link.
- Oversamples the host sclk/cs_n/mosi in the core clk domain and deserialises fixed-width frames {cmd, tile_i, tile_j, op_code, data}.
- Buffers complete frames in a small RX FIFO, presented to the NPU controller through a valid/ready handshake.
- Shifts a controller-supplied response word out on miso during the next frame.

Parameters:
- CMD_W, 8, command field width
- TILE_W, 3, width of each of tile_i and tile_j
- OP_W, 3, op_code width
- DATA_W, 8, data field width
- RSP_W, 8, response word width shifted on miso
- FIFO_DEPTH, 4, RX frame FIFO entries; power of two, at least 2
- SYNC_STAGES, 2, synchroniser flops on sclk, cs_n and mosi; at least 2

Ports:
- clk  in  1  core clock; must be at least 4x the sclk frequency
- rst  in  1  synchronous active-high reset
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  SPI data in, MSB first
- miso  out  1  SPI data out, MSB first
- cmd_valid  out  1  a frame is available at the FIFO head
- cmd_ready  in  1  consumer accepts the head frame
- cmd  out  CMD_W  head frame command field
- tile_i  out  TILE_W  head frame tile_i
- tile_j  out  TILE_W  head frame tile_j
- op_code  out  OP_W  head frame op_code
- data  out  DATA_W  head frame data field
- rsp_valid  in  1  response word is offered
- rsp_ready  out  1  response holding register is empty
- rsp_data  in  RSP_W  response word
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err  out  1  one-cycle pulse when a frame is dropped for a bad length or parity
- overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full

Behaviour:
- FRAME_W = CMD_W + 2*TILE_W + OP_W + DATA_W, which is 25 with the defaults. Bits arrive MSB first in the order cmd, tile_i, tile_j, op_code, data.
- Sampling:
  - sclk, cs_n and mosi pass through SYNC_STAGES flops.
  - Edge detectors produce sclk_rise, sclk_fall, cs_fall and cs_rise strobes on synchronised values.
  - mosi is sampled on sclk_rise only while cs_n is low.
- Receive state machine, states IDLE, SHIFT, CHECK:
  - IDLE -> SHIFT on cs_fall. Clear the bit counter and the shift register.
  - SHIFT: each sclk_rise shifts in one bit and increments the bit counter. The counter saturates at FRAME_W+1; extra bits are not stored.
  - SHIFT -> CHECK on cs_rise.
  - CHECK, one cycle:
    - count == FRAME_W and FIFO not full: push the frame.
    - count == FRAME_W and FIFO full: pulse overflow and drop the frame.
    - any other count, including 0: pulse frame_err and drop the frame.
  - CHECK -> IDLE.
- If cs_fall and cs_rise occur within one synchronised sample, the frame has count 0 and frame_err pulses.
- RX FIFO:
  - First-word fall-through: the head fields are valid whenever cmd_valid=1.
  - A pop occurs when cmd_valid && cmd_ready.
  - A push and a pop in the same cycle leave the level unchanged. A push into a full FIFO in the same cycle as a pop is accepted.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates in the cycle after the push or pop.
- Push latency: cmd_valid rises 2 clk after the synchronised cs_rise, i.e. the CHECK cycle plus the FIFO write.
- Response path:
  - rsp_ready = 1 while the holding register is empty. Loaded on rsp_valid && rsp_ready.
  - On cs_fall, the holding register copies into the TX shifter and the register is marked empty. If it is empty at that point, the TX shifter is loaded with all zeros.
  - miso drives the TX MSB from cs_fall. Each sclk_fall shifts left and fills with 0.
  - After RSP_W bits, miso = 0.
  - While cs_n is high, miso = 0.
- Reset values:
  - miso=0, cmd_valid=0, rsp_ready=1, fifo_level=0, frame_err=0, overflow=0.
  - Head fields are 0, the FIFO is emptied and the state machine returns to IDLE.
- Reset mid-frame aborts the frame without pushing it and without pulsing frame_err. A frame that starts with cs_n already low after reset is ignored until the next cs_fall.

Optional Feature:
- Macro NPU_SPI_PARITY_EN.
- When defined:
  - Every frame carries one extra trailing even-parity bit covering all FRAME_W bits, so the expected length is FRAME_W+1.
  - A parity mismatch pulses frame_err and drops the frame.
  - The response gains a trailing even-parity bit, so RSP_W+1 bits are shifted out.
- When undefined:
  - The expected length is exactly FRAME_W and no parity is checked or generated.

Test Plan:
- One 25-bit frame cmd=0x02, tile_i=0, tile_j=0, op=1, data=0x00 -> cmd_valid=1 with cmd=0x02, op_code=1, data=0x00; fifo_level=1; frame_err=0.
- Five frames with data 0x01..0x05 sent with cmd_ready=0 and FIFO_DEPTH=4 -> first four are stored; the fifth pulses overflow once; after popping, data reads 0x01, 0x02, 0x03, 0x04 in order.
- A 24-bit frame and a 26-bit frame -> frame_err pulses once each; fifo_level stays 0.
- rsp_data=0xA5 offered, then a frame sent -> miso bits read 1,0,1,0,0,1,0,1 on sclk rising edges, then 0; rsp_ready=1 after cs_fall.
- No response offered before a frame -> miso reads 0x00.
- rst asserted after 10 bits of a frame, then a full valid frame sent -> only the second frame appears; no frame_err pulse; all outputs are at reset values during rst.

Source files
------------

// File: rtl/npu_spi_frame_slave.sv
// SPI mode-0 slave: oversampled receive of {cmd, tile_i, tile_j, op_code, data} frames into a FWFT FIFO,
// with a response word shifted out on miso. Define NPU_SPI_PARITY_EN for trailing even parity on both directions.
module npu_spi_frame_slave #(
    parameter int CMD_W       = 8,
    parameter int TILE_W      = 3,
    parameter int OP_W        = 3,
    parameter int DATA_W      = 8,
    parameter int RSP_W       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sclk,
    input  logic                            cs_n,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [CMD_W-1:0]                cmd,
    output logic [TILE_W-1:0]               tile_i,
    output logic [TILE_W-1:0]               tile_j,
    output logic [OP_W-1:0]                 op_code,
    output logic [DATA_W-1:0]               data,
    input  logic                            rsp_valid,
    output logic                            rsp_ready,
    input  logic [RSP_W-1:0]                rsp_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_err,
    output logic                            overflow
);
    localparam int FRAME_W = CMD_W + 2*TILE_W + OP_W + DATA_W;
`ifdef NPU_SPI_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int RX_W  = FRAME_W + PAR;
    localparam int TX_W  = RSP_W + PAR;
    localparam int CNT_W = $clog2(RX_W + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(RX_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RX_W + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    // Synchronisers are deliberately not reset so they keep tracking the pins during rst.
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d;

    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        sclk_d    <= sclk_sync[SYNC_STAGES-1];
        cs_d      <= cs_sync[SYNC_STAGES-1];
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // A frame already in progress when reset lifts is ignored until cs_n has been seen high.
    logic armed, cs_start;
    always_ff @(posedge clk) begin
        if (rst)       armed <= 1'b0;
        else if (cs_s) armed <= 1'b1;
    end
    assign cs_start = cs_fall & armed;

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [RX_W-1:0]  sr;
    logic [FRAME_W-1:0] frame_in;
    logic len_ok, par_ok, full, push, pop, do_err, do_ovf;

    assign frame_in = sr[RX_W-1 -: FRAME_W];
    assign len_ok   = (cnt == CNT_GOOD);
`ifdef NPU_SPI_PARITY_EN
    assign par_ok   = ~^sr;
`else
    assign par_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        do_err   = 1'b0;
        do_ovf   = 1'b0;
        case (state)
            IDLE:  if (cs_start) state_nx = SHIFT;
            SHIFT: if (cs_rise)  state_nx = CHECK;
            CHECK: begin
                state_nx = IDLE;
                if (!(len_ok && par_ok)) do_err = 1'b1;
                else if (full && !pop)   do_ovf = 1'b1;
                else                     push   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else if (state == IDLE && cs_start) begin
            cnt <= '0;
            sr  <= '0;
        end else if (state == SHIFT && sclk_rise) begin
            if (cnt < CNT_GOOD) sr  <= {sr[RX_W-2:0], mosi_s};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= do_err;
            overflow  <= do_ovf;
        end
    end

    logic [FRAME_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [FRAME_W-1:0] head;

    assign cmd_valid  = (level != '0);
    assign full       = (level == LVL_FULL);
    assign pop        = cmd_valid & cmd_ready;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= frame_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head = cmd_valid ? mem[rd_ptr] : '0;
    assign {cmd, tile_i, tile_j, op_code, data} = head;

    logic [RSP_W-1:0] hold;
    logic             hold_full, tx_on;
    logic [TX_W-1:0]  tx_sh, tx_word;

`ifdef NPU_SPI_PARITY_EN
    assign tx_word = {hold, ^hold};
`else
    assign tx_word = hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            tx_sh     <= '0;
            tx_on     <= 1'b0;
        end else begin
            if (cs_start) begin
                tx_sh     <= hold_full ? tx_word : '0;
                tx_on     <= 1'b1;
                hold_full <= 1'b0;
            end else if (tx_on && sclk_fall) begin
                tx_sh <= {tx_sh[TX_W-2:0], 1'b0};
            end
            if (cs_rise) tx_on <= 1'b0;
            // A word offered on the cs_fall cycle waits for the following frame.
            if (rsp_valid && !hold_full) begin
                hold      <= rsp_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign rsp_ready = ~hold_full;
    assign miso      = tx_on & tx_sh[TX_W-1];
endmodule

// File: tb/tb_npu_spi_frame_slave.sv
// Directed bench for npu_spi_frame_slave: host SPI driver, frame scoreboard queue, pulse counters.
module tb_npu_spi_frame_slave;
    localparam int FRAME_W = 25;
    localparam int DEPTH   = 4;
`ifdef NPU_SPI_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int RX_W = FRAME_W + PAR;
    localparam int TX_W = 8 + PAR;

    logic clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0;
    logic cmd_ready = 0, rsp_valid = 0;
    logic [7:0] rsp_data = '0;
    logic miso, cmd_valid, rsp_ready, frame_err, overflow;
    logic [7:0] cmd, data;
    logic [2:0] tile_i, tile_j, op_code;
    logic [2:0] fifo_level;

    npu_spi_frame_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .tile_i(tile_i),
        .tile_j(tile_j), .op_code(op_code), .data(data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .fifo_level(fifo_level),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, err_cnt = 0, ovf_cnt = 0, model_lvl = 0;
    logic [FRAME_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (overflow === 1'b1)  ovf_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] mk(input logic [7:0] c, input logic [2:0] ti,
                                               input logic [2:0] tj, input logic [2:0] op,
                                               input logic [7:0] d);
        return {c, ti, tj, op, d};
    endfunction

    // Host side: 80 ns sclk (8 clk), mosi set while sclk low, miso captured on each rising edge.
    task automatic send_raw(input logic [63:0] bits, input int n, output logic [63:0] rx);
        rx = '0;
        cs_n = 0;
        #80;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #40 sclk = 1;
            rx = {rx[62:0], miso};
            #40 sclk = 0;
        end
        #40 cs_n = 1;
        mosi = 0;
        #160;
    endtask

    task automatic send_good(input logic [FRAME_W-1:0] f, output logic [63:0] rx);
        logic [63:0] b;
        b = '0;
`ifdef NPU_SPI_PARITY_EN
        b[RX_W-1:0] = {f, ^f};
`else
        b[RX_W-1:0] = f;
`endif
        if (model_lvl < DEPTH) begin
            exp_q.push_back(f);
            model_lvl++;
        end
        send_raw(b, RX_W, rx);
    endtask

    task automatic pop_check(input string tag);
        int w;
        logic [FRAME_W-1:0] f;
        w = 0;
        @(negedge clk);
        while (!cmd_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, " valid"}, 32'(cmd_valid), 32'd1);
        check({tag, " queued"}, 32'(exp_q.size() > 0), 32'd1);
        if (cmd_valid && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check({tag, " frame"}, 32'({cmd, tile_i, tile_j, op_code, data}), 32'(f));
            cmd_ready = 1;
            @(negedge clk);
            cmd_ready = 0;
            model_lvl--;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"}, 32'(miso), 32'd0);
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, " rsp_ready"}, 32'(rsp_ready), 32'd1);
        check({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " head"}, 32'({cmd, tile_i, tile_j, op_code, data}), 32'd0);
    endtask

    initial begin
        logic [63:0] rx, b, e;
        int e0, o0;

        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        repeat (3) @(negedge clk);

        // single frame
        e0 = err_cnt;
        send_good(mk(8'h02, 3'd0, 3'd0, 3'd1, 8'h00), rx);
        @(negedge clk);
        check("f1 cmd_valid", 32'(cmd_valid), 32'd1);
        check("f1 cmd", 32'(cmd), 32'h02);
        check("f1 op_code", 32'(op_code), 32'd1);
        check("f1 data", 32'(data), 32'h00);
        check("f1 level", 32'(fifo_level), 32'd1);
        check("f1 frame_err", 32'(err_cnt - e0), 32'd0);
        pop_check("f1 pop");

        // fill past depth
        o0 = ovf_cnt;
        for (int d = 1; d <= 5; d++) send_good(mk(8'h10, 3'd1, 3'd2, 3'd3, 8'(d)), rx);
        @(negedge clk);
        check("fill level", 32'(fifo_level), 32'd4);
        check("fill overflow", 32'(ovf_cnt - o0), 32'd1);
        for (int d = 1; d <= 4; d++) begin
            check("fill data order", 32'(data), 32'(d));
            pop_check("fill pop");
        end
        check("fill drained", 32'(fifo_level), 32'd0);

        // short and long frames
        e0 = err_cnt;
        b = 64'h0123_4567_89AB_CDEF;
        send_raw(b, RX_W - 1, rx);
        send_raw(b, RX_W + 1, rx);
        @(negedge clk);
        check("len frame_err", 32'(err_cnt - e0), 32'd2);
        check("len level", 32'(fifo_level), 32'd0);

        // response 0xA5
        rsp_data = 8'hA5;
        rsp_valid = 1;
        check("rsp ready empty", 32'(rsp_ready), 32'd1);
        @(negedge clk);
        rsp_valid = 0;
        check("rsp ready held", 32'(rsp_ready), 32'd0);
        send_good(mk(8'h03, 3'd4, 3'd5, 3'd6, 8'h07), rx);
        e = '0;
`ifdef NPU_SPI_PARITY_EN
        e[TX_W-1:0] = {8'hA5, ^8'hA5};
`else
        e[TX_W-1:0] = 8'hA5;
`endif
        e = e << (RX_W - TX_W);
        check("rsp miso bits", 32'(rx), 32'(e));
        check("rsp ready after", 32'(rsp_ready), 32'd1);
        pop_check("rsp pop");

        // no response offered
        send_good(mk(8'hFF, 3'd7, 3'd7, 3'd7, 8'hFF), rx);
        check("norsp miso bits", 32'(rx), 32'd0);
        pop_check("norsp pop");

        // reset mid-frame
        e0 = err_cnt;
        cs_n = 0;
        #80;
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            #40 sclk = 1;
            #40 sclk = 0;
        end
        @(negedge clk);
        rst = 1;
        repeat (4) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 0;
        exp_q.delete();
        model_lvl = 0;
        repeat (3) @(negedge clk);
        cs_n = 1;
        repeat (10) @(negedge clk);
        check("midrst stale", 32'(cmd_valid), 32'd0);
        send_good(mk(8'h09, 3'd1, 3'd1, 3'd1, 8'h5A), rx);
        @(negedge clk);
        check("midrst level", 32'(fifo_level), 32'd1);
        check("midrst frame_err", 32'(err_cnt - e0), 32'd0);
        pop_check("midrst pop");
        check("midrst empty", 32'(cmd_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
